conv_encoder_framed: RTL and testbench

Parametrised, frame-based convolutional FEC encoder with a valid/ready streaming interface. It is the successor to the fixed `encoder` stage in the `encoder_fec` chain.

- Encodes a serial bit stream with a rate-1/2 code of configurable constraint length and generator polynomials.
- Optionally punctures to rate 2/3.
- Terminates every frame with K-1 zero tail bits.
- Sits between the input circular buffer and the modulator.

---
 rtl/encoder_fec_pkg.sv | 30 +++
 rtl/conv_parity.sv | 16 +
 rtl/conv_encoder_framed.sv | 158 +++++++++++++++
 tb/tb_conv_encoder_framed.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_fec_pkg.sv
// Shared types and constants for the encoder_fec chain.
// Holds convolutional code config, rate selectors and FSM states.
package encoder_fec_pkg;

    typedef struct packed {
        logic [3:0] k;
        logic [8:0] g0;
        logic [8:0] g1;
    } conv_cfg_t;

    localparam logic ENC_RATE_1_2 = 1'b0;
    localparam logic ENC_RATE_2_3 = 1'b1;

    localparam logic [1:0] MASK_FULL  = 2'b11;
    localparam logic [1:0] MASK_PUNCT = 2'b01;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_DATA,
        ENC_TAIL
    } enc_state_e;

    function automatic logic [1:0] punct_mask(
        input logic rate,
        input logic phase
    );
        return (rate == ENC_RATE_2_3 && phase) ? MASK_PUNCT : MASK_FULL;
    endfunction

endpackage

// File: rtl/conv_parity.sv
// Combinational parity taps of the convolutional code.
// v[K-1] is the current input bit, lower bits the history.
module conv_parity #(
    parameter int K = 7
) (
    input  logic [K-1:0] v,
    input  logic [K-1:0] g0,
    input  logic [K-1:0] g1,
    output logic         c0,
    output logic         c1
);

    assign c0 = ^(v & g0);
    assign c1 = ^(v & g1);

endmodule

// File: rtl/conv_encoder_framed.sv
// Frame-based rate-1/2 convolutional encoder with optional 2/3
// puncturing, zero-tail termination and a single-entry output slot.
module conv_encoder_framed
    import encoder_fec_pkg::*;
#(
    parameter int             K         = 7,
    parameter logic [K-1:0]   G0        = 7'o171,
    parameter logic [K-1:0]   G1        = 7'o133,
    parameter int             FRAME_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rate_sel,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic [1:0] out_mask,
    output logic       out_last,
    output logic       frame_err
);

    localparam conv_cfg_t CFG = '{k: 4'(K), g0: 9'(G0), g1: 9'(G1)};
    localparam int CW = $clog2(FRAME_LEN);
    localparam int TW = $clog2(K);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TAIL_N   = TW'(CFG.k - 4'd1);

    enc_state_e    state, state_d;
    logic [K-2:0]  sr, sr_d;
    logic [CW-1:0] bit_cnt, bit_cnt_d;
    logic [TW-1:0] tail_cnt, tail_cnt_d;
    logic          phase, phase_d;
    logic          rate_q, rate_d;

    logic          slot_free;
    logic          accept;
    logic          tail_go;
    logic          load;
    logic          u;
    logic [K-1:0]  v;
    logic          c0, c1;
    logic [1:0]    mask_d;
    logic          last_d;
    logic          ferr_d;

    assign slot_free = !out_valid || out_ready;
    // Ready is gated by reset so the port reads 0 while rst_n is held.
    assign in_ready  = rst_n && en && (state != ENC_TAIL) && slot_free;
    assign accept    = in_valid && in_ready;
    assign tail_go   = (state == ENC_TAIL) && slot_free && en;
    assign load      = accept || tail_go;
    assign u         = (state == ENC_TAIL) ? 1'b0 : in_bit;
    assign v         = {u, sr};

    conv_parity #(
        .K (K)
    ) u_parity (
        .v  (v),
        .g0 (CFG.g0[K-1:0]),
        .g1 (CFG.g1[K-1:0]),
        .c0 (c0),
        .c1 (c1)
    );

    always_comb begin
        state_d    = state;
        sr_d       = sr;
        bit_cnt_d  = bit_cnt;
        tail_cnt_d = tail_cnt;
        phase_d    = phase;
        rate_d     = rate_q;
        mask_d     = MASK_FULL;
        last_d     = 1'b0;
        ferr_d     = 1'b0;

        unique case (state)
            ENC_IDLE: begin
                if (accept) begin
                    rate_d    = rate_sel;
                    bit_cnt_d = CW'(1);
                    phase_d   = (rate_sel == ENC_RATE_2_3);
                    sr_d      = v[K-1:1];
                    if (in_last) begin
                        state_d    = ENC_TAIL;
                        tail_cnt_d = TAIL_N;
                    end else begin
                        state_d = ENC_DATA;
                    end
                end
            end
            ENC_DATA: begin
                if (accept) begin
                    mask_d    = punct_mask(rate_q, phase);
                    phase_d   = (rate_q == ENC_RATE_2_3) && !phase;
                    sr_d      = v[K-1:1];
                    bit_cnt_d = bit_cnt + CW'(1);
                    if (in_last || bit_cnt == LAST_IDX) begin
                        state_d    = ENC_TAIL;
                        tail_cnt_d = TAIL_N;
                        ferr_d     = !in_last;
                    end
                end
            end
            ENC_TAIL: begin
                if (tail_go) begin
                    sr_d       = v[K-1:1];
                    tail_cnt_d = tail_cnt - TW'(1);
                    if (tail_cnt == TW'(1)) begin
                        last_d    = 1'b1;
                        state_d   = ENC_IDLE;
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                    end
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENC_IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            tail_cnt  <= '0;
            phase     <= 1'b0;
            rate_q    <= ENC_RATE_1_2;
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            out_mask  <= 2'b00;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            sr        <= sr_d;
            bit_cnt   <= bit_cnt_d;
            tail_cnt  <= tail_cnt_d;
            phase     <= phase_d;
            rate_q    <= rate_d;
            frame_err <= ferr_d;
            if (load) begin
                out_valid <= 1'b1;
                out_sym   <= {c1, c0};
                out_mask  <= mask_d;
                out_last  <= last_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Scoreboard bench for conv_encoder_framed (K=3, G0=111, G1=101).
// Directed frames plus randomized streams against a convolution model.
module tb_conv_encoder_framed;

    localparam int         K         = 3;
    localparam logic [2:0] G0        = 3'b111;
    localparam logic [2:0] G1        = 3'b101;
    localparam int         FRAME_LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rate_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic [1:0] out_mask;
    logic       out_last;
    logic       frame_err;

    conv_encoder_framed #(
        .K         (K),
        .G0        (G0),
        .G1        (G1),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rate_sel  (rate_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sym;
        logic [1:0] mask;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_ferr = 0;
    int   ferr_seen = 0;
    bit   rnd_mode = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: plain convolution over the frame plus K-1 zero tail.
    function automatic void emit_frame(input bit fr[$], input bit rate);
        int   n;
        int   total;
        bit   c0;
        bit   c1;
        bit   u;
        exp_t e;
        n     = fr.size();
        total = n + K - 1;
        for (int t = 0; t < total; t++) begin
            c0 = 0;
            c1 = 0;
            for (int j = 0; j < K; j++) begin
                u  = (t - j >= 0 && t - j < n) ? fr[t - j] : 1'b0;
                c0 = c0 ^ (u & G0[K - 1 - j]);
                c1 = c1 ^ (u & G1[K - 1 - j]);
            end
            e.sym  = {c1, c0};
            e.mask = (t < n && rate && (t % 2 == 1)) ? 2'b01 : 2'b11;
            e.last = (t == total - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void model_stream(input bit b[$], input bit l[$],
                                         input bit r[$]);
        bit fr[$];
        bit rate;
        rate = 0;
        for (int i = 0; i < b.size(); i++) begin
            if (fr.size() == 0) rate = r[i];
            fr.push_back(b[i]);
            if (l[i] || fr.size() == FRAME_LEN) begin
                if (!l[i]) exp_ferr++;
                emit_frame(fr, rate);
                fr.delete();
            end
        end
    endfunction

    // Test-plan reference sequence for the frame 1,0,1,1.
    function automatic void push_s1(input bit rate);
        logic [1:0] syms [6];
        logic [1:0] pm   [6];
        exp_t       e;
        syms = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        pm   = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b11};
        for (int i = 0; i < 6; i++) begin
            e.sym  = syms[i];
            e.mask = rate ? pm[i] : 2'b11;
            e.last = (i == 5);
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: pops on every output handshake, checks hold stability.
    logic       hold_p = 1'b0;
    logic       ferr_p = 1'b0;
    logic [4:0] prev_o = '0;
    logic [4:0] cur_o;
    exp_t       got_e;

    always @(negedge clk) begin
        cur_o = {out_sym, out_mask, out_last};
        if (!rst_n) begin
            hold_p = 1'b0;
            ferr_p = 1'b0;
        end else begin
            if (hold_p)
                check("hold_stable", {out_valid, cur_o}, {1'b1, prev_o});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_symbol");
                end else begin
                    got_e = exp_q.pop_front();
                    check("symbol", cur_o, got_e);
                end
            end
            if (frame_err) begin
                ferr_seen++;
                check("frame_err_single", ferr_p, 1'b0);
            end
            ferr_p = frame_err;
            hold_p = out_valid && !out_ready;
            prev_o = cur_o;
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
        end
    end

    task automatic drive_bit(input bit b, input bit l, input bit r);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        rate_sel = r;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 300);
        if (!in_ready) fail("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drive_s1(input bit r);
        drive_bit(1, 0, r);
        drive_bit(0, 0, r);
        drive_bit(1, 0, r);
        drive_bit(1, 1, r);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sym"}, out_sym, 0);
        check({tag, "_out_mask"}, out_mask, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    initial begin
        bit b[$];
        bit l[$];
        bit r[$];
        int len;

        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", in_ready, 1);

        // Rate 1/2 and punctured 2/3 reference frames.
        push_s1(0);
        drive_s1(0);
        wait_drain();
        push_s1(1);
        drive_s1(1);
        wait_drain();

        // Output backpressure for three cycles mid-frame.
        push_s1(0);
        drive_bit(1, 0, 0);
        drive_bit(0, 0, 0);
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_bit(1, 0, 0);
        drive_bit(1, 1, 0);
        wait_drain();

        // Forced termination at FRAME_LEN.
        b = '{1, 1, 0, 1, 0, 1};
        l = '{0, 0, 0, 0, 0, 1};
        r = '{0, 0, 0, 0, 0, 0};
        model_stream(b, l, r);
        for (int i = 0; i < 6; i++) begin
            drive_bit(b[i], l[i], r[i]);
            check("frame_err_timing", frame_err, (i == 3));
        end
        wait_drain();

        // Reset asserted while the tail is pending.
        push_s1(0);
        drive_s1(0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midtail_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_s1(0);
        drive_s1(0);
        wait_drain();

        // Enable low for two cycles with a pending symbol.
        push_s1(0);
        drive_bit(1, 0, 0);
        drive_bit(0, 0, 0);
        en       = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(negedge clk);
        check("en_off_ready0", in_ready, 0);
        check("en_off_pending", out_valid, 1);
        @(negedge clk);
        check("en_off_ready1", in_ready, 0);
        check("en_off_drained", out_valid, 0);
        @(posedge clk);
        #1;
        en = 1'b1;
        drive_bit(1, 0, 0);
        drive_bit(1, 1, 0);
        wait_drain();

        // Randomized streams with random backpressure and enable.
        rnd_mode = 1;
        for (int s = 0; s < 30; s++) begin
            b.delete();
            l.delete();
            r.delete();
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                b.push_back(1'($urandom_range(0, 1)));
                l.push_back((i == len - 1) || ($urandom_range(0, 3) == 0));
                r.push_back(1'($urandom_range(0, 1)));
            end
            model_stream(b, l, r);
            for (int i = 0; i < len; i++) drive_bit(b[i], l[i], r[i]);
        end
        rnd_mode = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        en        = 1'b1;
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        check("frame_err_count", ferr_seen, exp_ferr);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
